instr_mem_server: RTL and testbench

Instruction-memory responder for the fetch stage. It returns the 32-bit instruction word for the fetch address in the same cycle, so the fetch stage can decode branch offsets combinationally. It also contains a byte-stream program loader that fills the memory little-endian through a valid/ready handshake. While a load is in progress it stalls the core and serves NOPs.

---
 rtl/instr_mem_server.sv | 139 +++++++++++++
 tb/tb_instr_mem_server.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_server.sv
// Instruction memory for the fetch stage: same-cycle word read for the PC,
// plus a little-endian byte-stream loader that stalls the core while it runs.
module instr_mem_server #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_misaligned,
    input  logic        load_start,
    input  logic [15:0] load_words,
    input  logic [7:0]  load_byte,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        load_busy,
    output logic        load_done
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [1:0]     state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  count_q, count_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [23:0]    shreg_q, shreg_d;

    logic [PW-1:0]  clamp_count;
    logic           accept;
    logic           wr_en;
    logic [31:0]    wr_word;
    logic [AW-1:0]  word_idx;
    logic           in_range;

    // Requested word count clamped to the memory depth so the pointer never wraps
    always_comb begin
        clamp_count = PW'(DEPTH_WORDS);
        if (32'(load_words) < DEPTH_WORDS) begin
            clamp_count = PW'(load_words);
        end
    end

    assign accept  = (state_q == ST_LOAD) && load_valid;
    assign wr_en   = accept && (byte_cnt_q == 2'd3);
    assign wr_word = {load_byte, shreg_q};

    // Loader next-state and datapath update
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    count_d    = clamp_count;
                    ptr_d      = '0;
                    byte_cnt_d = 2'd0;
                    state_d    = (clamp_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: shreg_d[7:0]   = load_byte;
                        2'd1: shreg_d[15:8]  = load_byte;
                        2'd2: shreg_d[23:16] = load_byte;
                        default: begin
                            ptr_d = ptr_q + PW'(1);
                            if ((ptr_q + PW'(1)) == count_q) begin
                                state_d = ST_DONE;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and status-output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            byte_cnt_q <= 2'd0;
            shreg_q    <= '0;
            load_ready <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            load_ready <= (state_d == ST_LOAD);
            load_busy  <= (state_d != ST_IDLE);
            load_done  <= (state_d == ST_DONE);
        end
    end

    // Word write on the 4th accepted byte; a reset on that edge drops the partial word
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[ptr_q[AW-1:0]] <= wr_word;
        end
    end

    assign word_idx = fetch_addr[AW+1:2];
    assign in_range = (fetch_addr[31:AW+2] == '0);

    // Same-cycle instruction read; NOP while loading or outside the array
    always_comb begin
        fetch_data = mem[word_idx];
        if ((state_q == ST_LOAD) || !in_range) begin
            fetch_data = NOP_WORD;
        end
    end

    assign fetch_misaligned = (fetch_addr[1:0] != 2'b00);

endmodule

// File: tb/tb_instr_mem_server.sv
// Bench for instr_mem_server: loader scoreboard plus fetch vector table.
module tb_instr_mem_server;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_misaligned;
    logic        load_start;
    logic [15:0] load_words;
    logic [7:0]  load_byte;
    logic        load_valid;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[6];

    instr_mem_server #(
        .DEPTH_WORDS(1024),
        .NOP_WORD(32'h00000013)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_addr(fetch_addr),
        .fetch_data(fetch_data),
        .fetch_misaligned(fetch_misaligned),
        .load_start(load_start),
        .load_words(load_words),
        .load_byte(load_byte),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_busy(load_busy),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'(i), 8'hC3, 8'(i >> 8), 8'h3C};
    endfunction

    // Offer one byte, wait (bounded) for ready, then idle for gap cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        load_byte  = b;
        load_valid = 1'b1;
        while (!load_ready && n < 16) begin
            step();
            n++;
        end
        if (!load_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
        step();
        load_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input int gap);
        sb_t e;
        e.addr = 32'(idx * 4);
        e.data = w;
        sb_q.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic start_load(input int n, input logic with_byte);
        load_start = 1'b1;
        load_words = 16'(n);
        load_valid = with_byte;
        load_byte  = 8'hFF;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
    endtask

    // Called in the cycle after the final accepted byte
    task automatic finish_load(input string name);
        int d0 = done_cnt;
        check32({name, "_done"}, 32'(load_done), 32'd1);
        check32({name, "_done_ready"}, 32'(load_ready), 32'd0);
        check32({name, "_done_busy"}, 32'(load_busy), 32'd1);
        step();
        check32({name, "_idle_done"}, 32'(load_done), 32'd0);
        check32({name, "_idle_busy"}, 32'(load_busy), 32'd0);
        check32({name, "_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic drain(input string name);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            fetch_addr = e.addr;
            #1;
            check32(name, fetch_data, e.data);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_words = '0;
        load_byte  = '0;
        load_valid = 1'b0;
        repeat (3) step();
        check32("rst_ready", 32'(load_ready), 32'd0);
        check32("rst_busy", 32'(load_busy), 32'd0);
        check32("rst_done", 32'(load_done), 32'd0);
        reset_n = 1'b1;
        step();

        // Two-word load with gaps, a stray byte at start and a mid-load restart
        start_load(2, 1'b1);
        check32("start_ready", 32'(load_ready), 32'd1);
        check32("start_busy", 32'(load_busy), 32'd1);
        fetch_addr = 32'h0;
        #1;
        check32("load_nop", fetch_data, 32'h00000013);
        send_word(0, 32'h00000513, 3);
        load_start = 1'b1;
        load_words = 16'd5;
        step();
        load_start = 1'b0;
        check32("restart_ignored_ready", 32'(load_ready), 32'd1);
        send_word(1, 32'h00100593, 0);
        finish_load("load1");
        drain("load1_word");

        vecs[0] = '{"addr_0",    32'h00000000, 32'h00000513, 1'b0};
        vecs[1] = '{"addr_4",    32'h00000004, 32'h00100593, 1'b0};
        vecs[2] = '{"addr_6",    32'h00000006, 32'h00100593, 1'b1};
        vecs[3] = '{"addr_3",    32'h00000003, 32'h00000513, 1'b1};
        vecs[4] = '{"addr_1000", 32'h00001000, 32'h00000013, 1'b0};
        vecs[5] = '{"addr_high", 32'h80000004, 32'h00000013, 1'b0};
        for (int i = 0; i < 6; i++) begin
            fetch_addr = vecs[i].addr;
            #1;
            check32({vecs[i].name, "_data"}, fetch_data, vecs[i].exp_data);
            check32({vecs[i].name, "_mis"}, 32'(fetch_misaligned), 32'(vecs[i].exp_mis));
        end

        // Zero-length load goes straight to DONE
        start_load(0, 1'b0);
        finish_load("zero");
        check32("zero_ready", 32'(load_ready), 32'd0);
        fetch_addr = 32'h0;
        #1;
        check32("zero_unchanged", fetch_data, 32'h00000513);

        // Oversized request clamps to the full depth
        start_load(2000, 1'b0);
        for (int i = 0; i < 1024; i++) send_word(i, pat(i), 0);
        finish_load("big");
        drain("big_word");

        // Reset after 6 bytes of a 2-word load
        start_load(2, 1'b0);
        send_word(0, 32'hDEADBEEF, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        reset_n = 1'b0;
        step();
        check32("mid_rst_busy", 32'(load_busy), 32'd0);
        check32("mid_rst_ready", 32'(load_ready), 32'd0);
        check32("mid_rst_done", 32'(load_done), 32'd0);
        reset_n = 1'b1;
        begin
            sb_t e;
            e.addr = 32'h4;
            e.data = pat(1);
            sb_q.push_back(e);
        end
        drain("mid_rst_word");

        start_load(1, 1'b0);
        check32("post_rst_ready", 32'(load_ready), 32'd1);
        send_word(0, 32'h11223344, 0);
        finish_load("post_rst");
        drain("post_rst_word");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
